bank_biu_linefill_engine: RTL

Bank-side bus interface engine that produces the linefill return stream consumed by the bank ISU.
- Accepts linefill requests (set, way, line address) from the HTU.
- Issues 2-beat read bursts to memory, tagging each burst with ID = {set,way}.
- Assembles the two 128-bit beats of each burst into one 256-bit line.
- Drives that line to the ISU on the biu_isu_rvalid/rdata/rid interface.
- Tracks outstanding lines and flags memory/protocol errors.

---
 rtl/bank_biu_linefill_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bank_biu_linefill_engine.sv
// Linefill bus interface engine: queues HTU linefill requests, issues
// 2-beat read bursts tagged {set,way}, assembles the two 128-bit beats into
// one 256-bit line and hands it to the ISU.  Errors are collected in a sticky
// flag, and the number of lines in flight is tracked.
//
// Handshake rule for every channel (htu_biu, mem AR, mem R, biu_isu): a
// transfer happens on a rising clk_i edge where valid and ready are both
// high.  Once valid is raised it is held, with its payload unchanged, until
// that transfer happens.
module bank_biu_linefill_engine #(
   parameter int ADDR_W          = 32,
   parameter int REQ_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              htu_biu_valid_i,
   output logic              htu_biu_ready_o,
   input  logic [2:0]        htu_biu_set_i,
   input  logic [2:0]        htu_biu_way_i,
   input  logic [ADDR_W-1:0] htu_biu_addr_i,
   output logic              mem_arvalid_o,
   input  logic              mem_arready_i,
   output logic [ADDR_W-1:0] mem_araddr_o,
   output logic [5:0]        mem_arid_o,
   output logic [7:0]        mem_arlen_o,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o,
   input  logic [127:0]      mem_rdata_i,
   input  logic [5:0]        mem_rid_i,
   input  logic              mem_rlast_i,
   input  logic [1:0]        mem_rresp_i,
   output logic              biu_isu_rvalid_o,
   input  logic              biu_isu_rready_i,
   output logic [255:0]      biu_isu_rdata_o,
   output logic [5:0]        biu_isu_rid_o,
   output logic              biu_err_o,
   output logic [3:0]        biu_outstanding_o
);

   localparam int PTR_W = $clog2(REQ_DEPTH);
   localparam int ENT_W = ADDR_W + 6;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(REQ_DEPTH);
   localparam logic [3:0]     MAX_C   = 4'(MAX_OUTSTANDING);

   typedef enum logic {
      BEAT0 = 1'b0,
      BEAT1 = 1'b1
   } beat_e;

   // Request FIFO storage: {32B-aligned address, set, way}
   logic [ENT_W-1:0] fifo_mem [REQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fifo_cnt;
   logic [ENT_W-1:0] head;
   logic [ADDR_W-1:0] line_addr;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic beat_hs;
   logic isu_hs;

   beat_e        beat_state;
   logic [127:0] beat_lo;
   logic [5:0]   beat_id;

   assign line_addr   = htu_biu_addr_i & ~ADDR_W'(31);
   assign fifo_full   = (fifo_cnt == DEPTH_C);
   assign fifo_empty  = (fifo_cnt == '0);
   assign head        = fifo_mem[rd_ptr];

   assign htu_biu_ready_o = !fifo_full;
   assign push            = htu_biu_valid_i && htu_biu_ready_o;

   // AR is offered straight from the FIFO head; the outstanding limit only
   // rises through an AR transfer, so an offered AR cannot be withdrawn.
   assign mem_arvalid_o = !fifo_empty && (biu_outstanding_o < MAX_C);
   assign mem_araddr_o  = head[ENT_W-1:6];
   assign mem_arid_o    = head[5:0];
   assign mem_arlen_o   = 8'd1;
   assign pop           = mem_arvalid_o && mem_arready_i;

   // A new beat is taken only when the output line slot is free or draining.
   assign mem_rready_o = !biu_isu_rvalid_o || biu_isu_rready_i;
   assign beat_hs      = mem_rvalid_i && mem_rready_o;
   assign isu_hs       = biu_isu_rvalid_o && biu_isu_rready_i;

   // Request FIFO pointers, occupancy and storage
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < REQ_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {line_addr, htu_biu_set_i, htu_biu_way_i};
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Lines issued on AR but not yet handed to the ISU
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         biu_outstanding_o <= '0;
      end else begin
         case ({pop, isu_hs && (biu_outstanding_o != 4'd0)})
            2'b10:   biu_outstanding_o <= biu_outstanding_o + 1'b1;
            2'b01:   biu_outstanding_o <= biu_outstanding_o - 1'b1;
            default: biu_outstanding_o <= biu_outstanding_o;
         endcase
      end
   end

   // Beat assembly FSM with registered line output and sticky error
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         beat_state       <= BEAT0;
         beat_lo          <= '0;
         beat_id          <= '0;
         biu_isu_rvalid_o <= 1'b0;
         biu_isu_rdata_o  <= '0;
         biu_isu_rid_o    <= '0;
         biu_err_o        <= 1'b0;
      end else begin
         // Handoff empties the slot; a line loading this cycle overrides it.
         if (isu_hs) begin
            biu_isu_rvalid_o <= 1'b0;
            biu_isu_rdata_o  <= '0;
            biu_isu_rid_o    <= '0;
         end
         if (beat_hs) begin
            if (mem_rresp_i != 2'b00) biu_err_o <= 1'b1;
            case (beat_state)
               BEAT0: begin
                  if (mem_rlast_i) begin
                     // Short burst: deliver the lone beat as the low half.
                     biu_isu_rvalid_o <= 1'b1;
                     biu_isu_rdata_o  <= {128'd0, mem_rdata_i};
                     biu_isu_rid_o    <= mem_rid_i;
                     biu_err_o        <= 1'b1;
                  end else begin
                     beat_lo    <= mem_rdata_i;
                     beat_id    <= mem_rid_i;
                     beat_state <= BEAT1;
                  end
               end
               BEAT1: begin
                  biu_isu_rvalid_o <= 1'b1;
                  biu_isu_rdata_o  <= {mem_rdata_i, beat_lo};
                  biu_isu_rid_o    <= beat_id;
                  if ((mem_rid_i != beat_id) || !mem_rlast_i) biu_err_o <= 1'b1;
                  beat_state <= BEAT0;
               end
               default: beat_state <= BEAT0;
            endcase
         end
      end
   end

endmodule
